// File: rtl/udp_spam_checker.sv
// udp_spam_checker: sinks UDP RX packets, filters on destination port, checks every
// payload byte and the payload length, and keeps saturating soak-test statistics.
module udp_spam_checker #(
  parameter logic [15:0] UDP_PORT      = 16'd1234,
  parameter logic [7:0]  EXPECTED_BYTE = 8'd69,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  // UDP RX header bundle
  input  logic             hdr_valid,
  output logic             hdr_ready,
  input  logic [15:0]      dest_port,
  input  logic [15:0]      length,
  input  logic [31:0]      ip_source_ip,
  // UDP RX payload stream
  input  logic             tvalid,
  output logic             tready,
  input  logic [7:0]       tdata,
  input  logic             tlast,
  input  logic             tuser,
  // statistics
  input  logic             clear,
  output logic [CNT_W-1:0] good_count,
  output logic [CNT_W-1:0] bad_count,
  output logic [CNT_W-1:0] drop_count,
  output logic [CNT_W-1:0] byte_count,
  output logic [31:0]      last_src_ip,
  output logic             pkt_good,
  output logic             pkt_bad
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_ONE;
    end
  endfunction

  state_t           state_r;
  state_t           state_s;
  logic             hdr_ready_r;
  logic             tready_r;
  logic [15:0]      length_r;
  logic [31:0]      src_ip_r;
  logic [15:0]      beat_cnt_r;
  logic             err_r;
  logic [CNT_W-1:0] good_count_r;
  logic [CNT_W-1:0] bad_count_r;
  logic [CNT_W-1:0] drop_count_r;
  logic [CNT_W-1:0] byte_count_r;
  logic [31:0]      last_src_ip_r;
  logic             pkt_good_r;
  logic             pkt_bad_r;

  logic             hdr_fire_s;
  logic             beat_fire_s;
  logic             recv_beat_s;
  logic             pkt_done_s;
  logic             drop_done_s;
  logic             beat_err_s;
  logic [15:0]      pay_len_s;
  logic [16:0]      beat_next_s;
  logic             len_err_s;
  logic             final_err_s;
  logic             good_inc_s;
  logic             bad_inc_s;

  assign hdr_fire_s  = hdr_valid & hdr_ready_r;
  assign beat_fire_s = tvalid & tready_r;
  assign recv_beat_s = beat_fire_s & (state_r == ST_RECV);
  assign pkt_done_s  = recv_beat_s & tlast;
  assign drop_done_s = beat_fire_s & tlast & (state_r == ST_DRAIN);
  assign beat_err_s  = (tdata != EXPECTED_BYTE);

  // Payload length is the UDP length minus the 8-byte header; the 17-bit beat
  // count keeps a saturated beat_cnt from ever aliasing onto a valid length.
  assign pay_len_s   = length_r - 16'd8;
  assign beat_next_s = {1'b0, beat_cnt_r} + 17'd1;
  assign len_err_s   = (length_r < 16'd8) || (beat_next_s != {1'b0, pay_len_s});
  assign final_err_s = err_r | beat_err_s | tuser | len_err_s;
  assign good_inc_s  = pkt_done_s & ~final_err_s;
  assign bad_inc_s   = pkt_done_s & final_err_s;

  // Next-state decode for the packet FSM.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (hdr_fire_s) begin
          state_s = (dest_port == UDP_PORT) ? ST_RECV : ST_DRAIN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RECV, ST_DRAIN: begin
        if (beat_fire_s && tlast) begin
          state_s = ST_IDLE;
        end else begin
          state_s = state_r;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register with the handshake readies registered from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      hdr_ready_r <= 1'b1;
      tready_r    <= 1'b0;
    end else begin
      state_r     <= state_s;
      hdr_ready_r <= (state_s == ST_IDLE);
      tready_r    <= (state_s != ST_IDLE);
    end
  end

  // Per-packet context: header fields, beat count and sticky error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      length_r   <= 16'd0;
      src_ip_r   <= 32'd0;
      beat_cnt_r <= 16'd0;
      err_r      <= 1'b0;
    end else if (hdr_fire_s) begin
      length_r   <= length;
      src_ip_r   <= ip_source_ip;
      beat_cnt_r <= 16'd0;
      err_r      <= 1'b0;
    end else if (recv_beat_s) begin
      if (beat_cnt_r != 16'hFFFF) begin
        beat_cnt_r <= beat_cnt_r + 16'd1;
      end else begin
        beat_cnt_r <= beat_cnt_r;
      end
      err_r <= err_r | beat_err_s | (tlast & tuser);
    end else begin
      beat_cnt_r <= beat_cnt_r;
      err_r      <= err_r;
    end
  end

  // Saturating statistics counters; clear beats any same-cycle increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      good_count_r <= '0;
      bad_count_r  <= '0;
      drop_count_r <= '0;
      byte_count_r <= '0;
    end else if (clear) begin
      good_count_r <= '0;
      bad_count_r  <= '0;
      drop_count_r <= '0;
      byte_count_r <= '0;
    end else begin
      if (good_inc_s) good_count_r <= sat_inc(good_count_r);
      if (bad_inc_s) bad_count_r <= sat_inc(bad_count_r);
      if (drop_done_s) drop_count_r <= sat_inc(drop_count_r);
      if (recv_beat_s) byte_count_r <= sat_inc(byte_count_r);
    end
  end

  // Verdict pulses and source address of the most recent good packet.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pkt_good_r    <= 1'b0;
      pkt_bad_r     <= 1'b0;
      last_src_ip_r <= 32'd0;
    end else begin
      pkt_good_r <= good_inc_s;
      pkt_bad_r  <= bad_inc_s;
      if (good_inc_s) begin
        last_src_ip_r <= src_ip_r;
      end else begin
        last_src_ip_r <= last_src_ip_r;
      end
    end
  end

  assign hdr_ready   = hdr_ready_r;
  assign tready      = tready_r;
  assign good_count  = good_count_r;
  assign bad_count   = bad_count_r;
  assign drop_count  = drop_count_r;
  assign byte_count  = byte_count_r;
  assign last_src_ip = last_src_ip_r;
  assign pkt_good    = pkt_good_r;
  assign pkt_bad     = pkt_bad_r;

endmodule

// File: tb/tb_udp_spam_checker.sv
// tb_udp_spam_checker: directed vectors for udp_spam_checker; a second CNT_W=4
// instance sharing the same stimulus exercises counter saturation.
module tb_udp_spam_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        hdr_valid = 1'b0;
  logic [15:0] dest_port = 16'd0;
  logic [15:0] length = 16'd0;
  logic [31:0] ip_source_ip = 32'd0;
  logic        tvalid = 1'b0;
  logic [7:0]  tdata = 8'd0;
  logic        tlast = 1'b0;
  logic        tuser = 1'b0;
  logic        clear = 1'b0;

  logic        hdr_ready, tready, pkt_good, pkt_bad;
  logic [31:0] good_count, bad_count, drop_count, byte_count, last_src_ip;
  logic        s_hdr_ready, s_tready, s_pkt_good, s_pkt_bad;
  logic [3:0]  s_good, s_bad, s_drop, s_byte;
  logic [31:0] s_last_ip;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  udp_spam_checker dut (
    .clk(clk), .reset(reset),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .dest_port(dest_port),
    .length(length), .ip_source_ip(ip_source_ip),
    .tvalid(tvalid), .tready(tready), .tdata(tdata), .tlast(tlast), .tuser(tuser),
    .clear(clear), .good_count(good_count), .bad_count(bad_count),
    .drop_count(drop_count), .byte_count(byte_count), .last_src_ip(last_src_ip),
    .pkt_good(pkt_good), .pkt_bad(pkt_bad)
  );

  udp_spam_checker #(.CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset),
    .hdr_valid(hdr_valid), .hdr_ready(s_hdr_ready), .dest_port(dest_port),
    .length(length), .ip_source_ip(ip_source_ip),
    .tvalid(tvalid), .tready(s_tready), .tdata(tdata), .tlast(tlast), .tuser(tuser),
    .clear(clear), .good_count(s_good), .bad_count(s_bad),
    .drop_count(s_drop), .byte_count(s_byte), .last_src_ip(s_last_ip),
    .pkt_good(s_pkt_good), .pkt_bad(s_pkt_bad)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_stats(input string tag, input int g, input int b, input int d, input int by);
    check_eq({tag, "_good"}, good_count, g);
    check_eq({tag, "_bad"}, bad_count, b);
    check_eq({tag, "_drop"}, drop_count, d);
    check_eq({tag, "_byte"}, byte_count, by);
  endtask

  // Called at posedge+1; returns at posedge+1 after the header handshake edge.
  task automatic send_hdr(input logic [15:0] p, input logic [15:0] l, input logic [31:0] ip);
    int n = 0;
    hdr_valid = 1'b1; dest_port = p; length = l; ip_source_ip = ip;
    while (!hdr_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check_eq("hdr_ready_wait", hdr_ready, 1'b1);
    @(posedge clk); #1;
    hdr_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic last, input logic usr, input int gap);
    int n = 0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    tvalid = 1'b1; tdata = d; tlast = last; tuser = usr;
    while (!tready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check_eq("tready_wait", tready, 1'b1);
    @(posedge clk); #1;
    tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
  endtask

  task automatic send_pkt(input logic [15:0] p, input logic [15:0] l, input logic [31:0] ip,
                          input int nb, input int bad_idx, input logic usr, input int maxgap);
    send_hdr(p, l, ip);
    for (int i = 0; i < nb; i++) begin
      send_beat((i == bad_idx) ? 8'd70 : 8'd69, (i == nb - 1), usr && (i == nb - 1),
                int'($urandom_range(maxgap, 0)));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_hdr_ready", hdr_ready, 1'b1);
    check_eq("rst_tready", tready, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    check_stats("rst", 0, 0, 0, 0);
    check_eq("rst_ip", last_src_ip, 32'd0);
    check_eq("rst_pulses", {pkt_good, pkt_bad}, 2'b00);

    // 1: single-beat good packet
    send_hdr(16'd1234, 16'd9, 32'hC0A8_0001);
    check_eq("t1_tready", tready, 1'b1);
    check_eq("t1_hdr_busy", hdr_ready, 1'b0);
    send_beat(8'd69, 1'b1, 1'b0, 0);
    check_eq("t1_pkt_good", pkt_good, 1'b1);
    check_eq("t1_pkt_bad", pkt_bad, 1'b0);
    check_eq("t1_idle", hdr_ready, 1'b1);
    check_stats("t1", 1, 0, 0, 1);
    check_eq("t1_ip", last_src_ip, 32'hC0A8_0001);
    @(posedge clk); #1;
    check_eq("t1_pulse_end", pkt_good, 1'b0);

    // 2: bad byte in a 4-byte payload
    send_pkt(16'd1234, 16'd12, 32'hC0A8_0002, 4, 2, 1'b0, 1);
    check_eq("t2_pkt_bad", pkt_bad, 1'b1);
    check_eq("t2_pkt_good", pkt_good, 1'b0);
    check_stats("t2", 1, 1, 0, 5);
    check_eq("t2_ip", last_src_ip, 32'hC0A8_0001);

    // 3: foreign port drained
    send_pkt(16'd80, 16'd11, 32'hC0A8_0003, 3, -1, 1'b0, 2);
    check_eq("t3_pulses", {pkt_good, pkt_bad}, 2'b00);
    check_stats("t3", 1, 1, 1, 5);

    // 4: length mismatch, tuser, short length, multi-beat good
    send_pkt(16'd1234, 16'd10, 32'hC0A8_0004, 1, -1, 1'b0, 0);
    check_eq("t4a_pkt_bad", pkt_bad, 1'b1);
    check_stats("t4a", 1, 2, 1, 6);
    send_pkt(16'd1234, 16'd9, 32'hC0A8_0005, 1, -1, 1'b1, 0);
    check_eq("t4b_pkt_bad", pkt_bad, 1'b1);
    check_stats("t4b", 1, 3, 1, 7);
    send_pkt(16'd1234, 16'd7, 32'hC0A8_0006, 1, -1, 1'b0, 0);
    check_eq("t4c_pkt_bad", pkt_bad, 1'b1);
    check_stats("t4c", 1, 4, 1, 8);
    send_pkt(16'd1234, 16'd11, 32'hC0A8_0007, 3, -1, 1'b0, 2);
    check_eq("t4d_pkt_good", pkt_good, 1'b1);
    check_stats("t4d", 2, 4, 1, 11);
    check_eq("t4d_ip", last_src_ip, 32'hC0A8_0007);

    // 5: clear, 100 back-to-back good packets, then clear racing an increment
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check_stats("t5_clr", 0, 0, 0, 0);
    check_eq("t5_clr_ip", last_src_ip, 32'hC0A8_0007);
    for (int k = 0; k < 100; k++) begin
      send_pkt(16'd1234, 16'd9, 32'h0A00_0000 + k, 1, -1, 1'b0, 3);
    end
    check_stats("t5_100", 100, 0, 0, 100);
    check_eq("t5_ip", last_src_ip, 32'h0A00_0063);
    send_hdr(16'd1234, 16'd9, 32'h0A00_0100);
    clear = 1'b1;
    send_beat(8'd69, 1'b1, 1'b0, 0);
    clear = 1'b0;
    check_stats("t5_race", 0, 0, 0, 0);
    check_eq("t5_race_pulse", pkt_good, 1'b1);
    check_eq("t5_race_ip", last_src_ip, 32'h0A00_0100);

    // 6: saturation on the 4-bit instance, then reset mid-RECV
    for (int k = 0; k < 17; k++) begin
      send_pkt(16'd1234, 16'd9, 32'h0B00_0000 + k, 1, -1, 1'b0, 1);
    end
    check_stats("t6_main", 17, 0, 0, 17);
    check_eq("t6_sat_good", s_good, 4'hF);
    check_eq("t6_sat_byte", s_byte, 4'hF);
    check_eq("t6_sat_bad", s_bad, 4'h0);
    send_hdr(16'd1234, 16'd12, 32'h0C00_0001);
    send_beat(8'd69, 1'b0, 1'b0, 0);
    check_stats("t6_mid", 17, 0, 0, 18);
    reset = 1'b0;
    #1;
    check_stats("t6_rst", 0, 0, 0, 0);
    check_eq("t6_rst_ip", last_src_ip, 32'd0);
    check_eq("t6_rst_hdr_ready", hdr_ready, 1'b1);
    check_eq("t6_rst_tready", tready, 1'b0);
    check_eq("t6_rst_sat", s_good, 4'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    send_pkt(16'd1234, 16'd9, 32'h0C00_0002, 1, -1, 1'b0, 0);
    check_eq("t6_post_pkt_good", pkt_good, 1'b1);
    check_stats("t6_post", 1, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
